apb_soc_cfg_seq: RTL and testbench

- APB master that programs the SoC control/pad-config register block after boot or on request.
- Writes pad mux, clock gate, boot address and eight pad-config words, reads every one back to verify, then writes the result code into the STATUS register.
- Sits between the boot/power controller (start/done handshake) and the control-register APB slave port. Sole master on that port.

---
 rtl/apb_soc_cfg_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_apb_soc_cfg_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_soc_cfg_seq.sv
// Purpose: APB master that programs the SoC control/pad-config block, reads every word back and posts a STATUS code.
// Latency: first SETUP one cycle after start_i; 2 cycles per zero-wait transfer; done_o 47 cycles after start.
// Backpressure: PREADY low stretches ACCESS; TIMEOUT consecutive wait cycles abort the sequence.
module apb_soc_cfg_seq #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          TIMEOUT        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      start_i,
    input  logic [31:0]               pad_mux_i,
    input  logic [31:0]               clk_gate_i,
    input  logic [31:0]               boot_addr_i,
    input  logic [7:0][31:0]          pad_cfg_i,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [3:0]                err_idx_o
);

    // Transfer list: 0..10 writes, 11..21 read-backs in the same order, 22 STATUS write.
    localparam logic [4:0]  LAST_WR_IDX = 5'd10;
    localparam logic [4:0]  LAST_RD_IDX = 5'd21;
    localparam logic [4:0]  STATUS_IDX  = 5'd22;
    localparam logic [4:0]  RD_BASE_IDX = 5'd11;
    localparam logic [7:0]  STATUS_OFF  = 8'h14;
    localparam logic [7:0]  WAIT_LIMIT  = 8'(TIMEOUT - 1);
    localparam logic [31:0] BASE32      = 32'(BASE_ADDR);
    localparam logic [31:0] MASK_FULL   = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_PAD    = 32'h3F3F_3F3F;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_SLVERR   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       idx_q;
    logic [7:0]       wait_q;
    logic [1:0]       err_code_q;
    logic [4:0]       err_idx_q;

    logic [31:0]      sh_pad_mux;
    logic [31:0]      sh_clk_gate;
    logic [31:0]      sh_boot_addr;
    logic [7:0][31:0] sh_pad_cfg;

    // Decoded view of the current transfer.
    logic             is_write;
    logic             is_status;
    logic [4:0]       pos;
    logic [4:0]       pcfg_sel;
    logic [7:0]       offset;
    logic [31:0]      addr_sum;
    logic [31:0]      shadow_word;
    logic [31:0]      cmp_mask;
    logic [31:0]      wr_data;

    // Per-cycle events while in ACCESS.
    logic             start_acc;
    logic             xfer_ok;
    logic             slv_err;
    logic             tmo_hit;
    logic             rd_mismatch;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign xfer_ok   = (state_q == S_ACCESS) && PREADY;
    assign slv_err   = xfer_ok && PSLVERR;
    assign tmo_hit   = (state_q == S_ACCESS) && !PREADY && (wait_q >= WAIT_LIMIT);

    // Decode index into list position, address offset, shadow word and compare mask.
    always_comb begin
        is_status   = (idx_q == STATUS_IDX);
        is_write    = (idx_q <= LAST_WR_IDX) || is_status;
        pos         = (idx_q <= LAST_WR_IDX) ? idx_q : (idx_q - RD_BASE_IDX);
        pcfg_sel    = pos - 5'd3;
        if (is_status) begin
            offset = STATUS_OFF;
        end else if (pos < 5'd3) begin
            offset = {1'b0, pos, 2'b00};
        end else begin
            // 0x20 + 4*(pos-3) collapses to 0x14 + 4*pos.
            offset = STATUS_OFF + {1'b0, pos, 2'b00};
        end
        addr_sum    = BASE32 + {24'b0, offset};
        shadow_word = 32'h0;
        case (pos)
            5'd0:    shadow_word = sh_pad_mux;
            5'd1:    shadow_word = sh_clk_gate;
            5'd2:    shadow_word = sh_boot_addr;
            default: shadow_word = sh_pad_cfg[pcfg_sel[2:0]];
        endcase
        cmp_mask    = (pos < 5'd3) ? MASK_FULL : MASK_PAD;
        // STATUS can only carry the mismatch code: any abort skips it.
        wr_data     = is_status ? {30'b0, (err_code_q == ERR_MISMATCH), 1'b0} : shadow_word;
    end

    assign rd_mismatch = xfer_ok && !PSLVERR && !is_write &&
                         (((PRDATA ^ shadow_word) & cmp_mask) != 32'h0);

    // FSM state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: back-to-back transfers, abort straight to DONE on error or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (slv_err || tmo_hit) begin
                    state_d = S_DONE;
                end else if (xfer_ok) begin
                    state_d = is_status ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: APB signals are decoded from state so a reset drops them immediately.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = 32'h0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            S_SETUP, S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state_q == S_ACCESS);
                PWRITE  = is_write;
                PADDR   = addr_sum[APB_ADDR_WIDTH-1:0];
                PWDATA  = is_write ? wr_data : 32'h0;
                busy_o  = 1'b1;
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                err_o   = (err_code_q != ERR_NONE);
            end
            default: begin
                // Result stays visible in IDLE until the next start.
                err_o   = (err_code_q != ERR_NONE);
            end
        endcase
    end

    // Transfer index and ACCESS wait counter (saturating).
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            idx_q  <= 5'd0;
            wait_q <= 8'd0;
        end else begin
            if (start_acc) begin
                idx_q <= 5'd0;
            end else if (xfer_ok && !PSLVERR && !is_status) begin
                idx_q <= idx_q + 5'd1;
            end
            if (state_q == S_SETUP) begin
                wait_q <= 8'd0;
            end else if ((state_q == S_ACCESS) && !PREADY && (wait_q != 8'hFF)) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    // Shadow copy of the configuration taken at start; inputs may change while busy.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sh_pad_mux   <= 32'h0;
            sh_clk_gate  <= 32'h0;
            sh_boot_addr <= 32'h0;
            sh_pad_cfg   <= '0;
        end else if (start_acc) begin
            sh_pad_mux   <= pad_mux_i;
            sh_clk_gate  <= clk_gate_i;
            sh_boot_addr <= boot_addr_i;
            sh_pad_cfg   <= pad_cfg_i;
        end
    end

    // Error record: first mismatch fixes the index; a later abort upgrades the code only.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_code_q <= ERR_NONE;
            err_idx_q  <= 5'd0;
        end else begin
            if (start_acc) begin
                err_code_q <= ERR_NONE;
                err_idx_q  <= 5'd0;
            end else if (slv_err || tmo_hit) begin
                err_code_q <= slv_err ? ERR_SLVERR : ERR_TIMEOUT;
                if (err_code_q == ERR_NONE) begin
                    err_idx_q <= idx_q;
                end
            end else if (rd_mismatch && (err_code_q == ERR_NONE)) begin
                err_code_q <= ERR_MISMATCH;
                err_idx_q  <= idx_q;
            end
        end
    end

    assign err_code_o = err_code_q;
    // Index port is 4 bits wide; indices 16..22 are reported modulo 16.
    assign err_idx_o  = err_idx_q[3:0];

endmodule

// File: tb/tb_apb_soc_cfg_seq.sv
module tb_apb_soc_cfg_seq;

    localparam int          AW   = 12;
    localparam int          TMO  = 16;
    localparam int unsigned BASE = 32'hFF0;
    localparam int          NX   = 23;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             start_i;
    logic [31:0]      pad_mux_i;
    logic [31:0]      clk_gate_i;
    logic [31:0]      boot_addr_i;
    logic [7:0][31:0] pad_cfg_i;
    logic [AW-1:0]    PADDR;
    logic [31:0]      PWDATA;
    logic             PWRITE;
    logic             PSEL;
    logic             PENABLE;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [3:0]       err_idx_o;

    apb_soc_cfg_seq #(
        .APB_ADDR_WIDTH (AW),
        .BASE_ADDR      (BASE),
        .TIMEOUT        (TMO)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .start_i     (start_i),
        .pad_mux_i   (pad_mux_i),
        .clk_gate_i  (clk_gate_i),
        .boot_addr_i (boot_addr_i),
        .pad_cfg_i   (pad_cfg_i),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .err_idx_o   (err_idx_o)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard queues.
    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wdata;
    } xfer_t;
    typedef struct {
        int          cyc;
        logic [1:0]  code;
        logic [3:0]  idx;
    } res_t;
    xfer_t exp_q[$];
    res_t  res_q[$];

    // Slave behaviour knobs, set by the stimulus.
    int          w        = 0;
    int          stall_tr = -1;
    int          err_tr   = -1;
    bit          ov_vld[NX];
    logic [31:0] ov_val[NX];

    logic [31:0] shv[11];
    logic [1:0]  last_code;
    logic [3:0]  last_idx;

    // ---------------- reference model ----------------
    function automatic logic [AW-1:0] addr_of(input int p);
        logic [31:0] a;
        if (p < 0)      a = BASE + 32'h14;
        else if (p < 3) a = BASE + 32'(4 * p);
        else            a = BASE + 32'h20 + 32'(4 * (p - 3));
        return a[AW-1:0];
    endfunction

    function automatic logic [31:0] in_val(input int p);
        if (p == 0) return pad_mux_i;
        if (p == 1) return clk_gate_i;
        if (p == 2) return boot_addr_i;
        return pad_cfg_i[p - 3];
    endfunction

    task automatic build_model(input int n0);
        int          t;
        int          p;
        logic [1:0]  code;
        logic [4:0]  idx;
        logic [31:0] rd;
        logic [31:0] msk;
        xfer_t       x;
        t    = n0 + 1;
        code = 2'd0;
        idx  = 5'd0;
        for (int k = 0; k < NX; k++) begin
            p       = (k < 11) ? k : (k < 22) ? k - 11 : -1;
            x.addr  = addr_of(p);
            x.wr    = (k < 11) || (k == 22);
            x.wdata = (k < 11) ? shv[p] : (k == 22) ? ((code == 2'd1) ? 32'h2 : 32'h0) : 32'h0;
            exp_q.push_back(x);
            if (k == stall_tr) begin
                t += 1 + TMO;
                if (code == 2'd0) idx = 5'(k);
                code = 2'd3;
                break;
            end
            t += 2 + w;
            if (k == err_tr) begin
                if (code == 2'd0) idx = 5'(k);
                code = 2'd2;
                break;
            end
            if (k >= 11 && k < 22) begin
                rd  = ov_vld[k] ? ov_val[k] : shv[p];
                msk = (p < 3) ? 32'hFFFF_FFFF : 32'h3F3F_3F3F;
                if (((rd & msk) != (shv[p] & msk)) && code == 2'd0) begin
                    code = 2'd1;
                    idx  = 5'(k);
                end
            end
        end
        res_q.push_back('{t, code, idx[3:0]});
        last_code = code;
        last_idx  = idx[3:0];
    endtask

    // ---------------- slave model ----------------
    int          s_tr  = 0;
    int          s_acc = 0;
    logic [31:0] mem [0:(1<<AW)-1];

    always @(negedge HCLK) begin
        if (!busy_o) begin
            s_tr  = 0;
            s_acc = 0;
        end
        if (PSEL && PENABLE) begin
            if (s_tr != stall_tr && s_acc >= w) begin
                PREADY  = 1'b1;
                PSLVERR = (s_tr == err_tr);
                if (PWRITE) begin
                    mem[PADDR] = PWDATA;
                    PRDATA     = $urandom();
                end else begin
                    PRDATA = (s_tr < NX && ov_vld[s_tr]) ? ov_val[s_tr] : mem[PADDR];
                end
                s_tr++;
                s_acc = 0;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom();
                s_acc++;
            end
        end else begin
            PREADY  = 1'($urandom_range(0, 1));
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom();
        end
    end

    // ---------------- monitor ----------------
    logic [44:0] cap;
    always @(negedge HCLK) begin
        xfer_t x;
        res_t  r;
        if (!HRESET) begin
            if (PSEL && !PENABLE) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_xfer");
                end else begin
                    x = exp_q.pop_front();
                    check("xfer", {PADDR, PWRITE, PWRITE ? PWDATA : 32'h0}, {x.addr, x.wr, x.wdata});
                end
                cap = {PADDR, PWRITE, PWDATA};
            end else if (PSEL && PENABLE) begin
                check("access_hold", {PADDR, PWRITE, PWDATA}, cap);
            end
            if (done_o) begin
                if (res_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    r = res_q.pop_front();
                    check("done_cycle", cyc, r.cyc);
                    check("err_code", err_code_o, r.code);
                    check("err_idx", err_idx_o, r.idx);
                    check("err_o_done", err_o, r.code != 2'd0);
                    check("done_apb_idle", {PSEL, PENABLE}, 2'b00);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_knobs();
        w        = 0;
        stall_tr = -1;
        err_tr   = -1;
        for (int k = 0; k < NX; k++) begin
            ov_vld[k] = 1'b0;
            ov_val[k] = 32'h0;
        end
    endtask

    task automatic rand_inputs();
        pad_mux_i   = $urandom();
        clk_gate_i  = $urandom();
        boot_addr_i = $urandom();
        for (int j = 0; j < 8; j++) pad_cfg_i[j] = $urandom();
    endtask

    task automatic launch(output int n0);
        @(negedge HCLK);
        start_i = 1'b1;
        n0      = cyc;
        for (int p = 0; p < 11; p++) shv[p] = in_val(p);
        build_model(n0);
        @(negedge HCLK);
        start_i = 1'b0;
        rand_inputs();
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        exp_q.delete();
        res_q.delete();
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((res_q.size() != 0 || busy_o) && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= budget) begin
            fail_now("done_wait_expired");
            do_reset();
        end else begin
            @(negedge HCLK);
            check("err_o_hold", err_o, last_code != 2'd0);
            check("err_code_hold", err_code_o, last_code);
            check("err_idx_hold", err_idx_o, last_idx);
            check("xfers_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        HRESET  = 1'b1;
        start_i = 1'b0;
        pad_mux_i = 32'h0; clk_gate_i = 32'h0; boot_addr_i = 32'h0; pad_cfg_i = '0;
        clear_knobs();
        repeat (3) @(negedge HCLK);
        check("reset_outputs",
              {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy_o, done_o, err_o, err_code_o, err_idx_o}, 64'h0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Echo slave, nominal values.
        pad_mux_i = 32'h1; clk_gate_i = 32'hFFFF_FFFF; boot_addr_i = 32'h8000;
        for (int j = 0; j < 8; j++) pad_cfg_i[j] = 32'h3F3F_3F3F;
        launch(n0);
        wait_done(200);

        // Mismatches at 13 (boot addr) and 15 (pad cfg): first one recorded, reads continue.
        pad_mux_i = 32'h1; clk_gate_i = 32'hFFFF_FFFF; boot_addr_i = 32'h8000;
        for (int j = 0; j < 8; j++) pad_cfg_i[j] = 32'h3F3F_3F3F;
        clear_knobs();
        ov_vld[13] = 1'b1; ov_val[13] = 32'h0;
        ov_vld[15] = 1'b1; ov_val[15] = 32'h3F3F_3F3E;
        launch(n0);
        wait_done(200);

        // Unused pad-config bits set on read: masked out.
        pad_mux_i = 32'h1; clk_gate_i = 32'hFFFF_FFFF; boot_addr_i = 32'h8000;
        for (int j = 0; j < 8; j++) pad_cfg_i[j] = 32'h3F3F_3F3F;
        clear_knobs();
        ov_vld[16] = 1'b1; ov_val[16] = 32'hFF3F_3F3F;
        launch(n0);
        wait_done(200);

        // PSLVERR on transfer 4.
        clear_knobs();
        rand_inputs();
        err_tr = 4;
        launch(n0);
        wait_done(200);

        // Slave never ready on transfer 0.
        clear_knobs();
        rand_inputs();
        stall_tr = 0;
        launch(n0);
        wait_done(200);

        // Two wait cycles per transfer, start pulses while busy are ignored.
        clear_knobs();
        rand_inputs();
        w = 2;
        launch(n0);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            start_i = 1'b1;
            @(negedge HCLK);
            start_i = 1'b0;
        end
        wait_done(300);

        // Reset during the ACCESS of transfer 7.
        clear_knobs();
        rand_inputs();
        launch(n0);
        while (cyc < n0 + 16) @(negedge HCLK);
        check("access_before_rst", {PSEL, PENABLE, PADDR}, {2'b11, addr_of(7)});
        #2 HRESET = 1'b1;
        #1 check("rst_drop", {PSEL, PENABLE, busy_o, PADDR}, 0);
        exp_q.delete();
        res_q.delete();
        @(negedge HCLK);
        check("rst_err_clear", {err_o, err_code_o, err_idx_o}, 0);
        HRESET = 1'b0;

        // Randomized sequences.
        for (int it = 0; it < 10; it++) begin
            clear_knobs();
            rand_inputs();
            w = $urandom_range(0, 3);
            for (int k = 11; k < 22; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ov_vld[k] = 1'b1;
                    ov_val[k] = in_val(k - 11) ^ (32'h1 << $urandom_range(0, 31));
                end
            end
            if ($urandom_range(0, 3) == 0) err_tr   = $urandom_range(0, 22);
            if ($urandom_range(0, 4) == 0) stall_tr = $urandom_range(0, 22);
            launch(n0);
            wait_done(400);
        end

        repeat (3) @(negedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
